// File: rtl/unified_mem_arb_if.sv
// Request/response and SRAM-side signal bundle for the unified memory arbiter.
// slave = arbiter view, master = core/host/SRAM environment view.
interface unified_mem_arb_if #(
    parameter int AW = 15
);
    logic          i_req;
    logic [15:0]   i_addr;
    logic [15:0]   i_rdata;
    logic          i_rvalid;

    logic          d_oe;
    logic          d_we0;
    logic          d_we1;
    logic [15:0]   d_addr;
    logic [15:0]   d_wdata;
    logic [15:0]   d_rdata;
    logic          d_rvalid;

    logic          h_req;
    logic          h_we;
    logic [15:0]   h_addr;
    logic [15:0]   h_wdata;
    logic          h_gnt;
    logic [15:0]   h_rdata;
    logic          h_rvalid;
    logic          h_lock;
    logic          h_locked;

    logic          core_stall;

    logic          m_en;
    logic [1:0]    m_we;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_wdata;
    logic [15:0]   m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_rvalid,
        input  d_oe, d_we0, d_we1, d_addr, d_wdata,
        output d_rdata, d_rvalid,
        input  h_req, h_we, h_addr, h_wdata, h_lock,
        output h_gnt, h_rdata, h_rvalid, h_locked,
        output core_stall,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_rvalid,
        output d_oe, d_we0, d_we1, d_addr, d_wdata,
        input  d_rdata, d_rvalid,
        output h_req, h_we, h_addr, h_wdata, h_lock,
        input  h_gnt, h_rdata, h_rvalid, h_locked,
        input  core_stall,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/unified_mem_arb.sv
// Single-port SRAM arbiter for fetch/data/host; one grant per cycle, read data 1 cycle after grant.
// No backpressure on the SRAM side; losing core requests raise core_stall, host lock stalls the core.
module unified_mem_arb #(
    parameter int AW     = 15,
    parameter int STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    unified_mem_arb_if.slave  bus
);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_I    = 2'd1;
    localparam logic [1:0] TAG_D    = 2'd2;
    localparam logic [1:0] TAG_H    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    tag_q, tag_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          dreq, d_wr;
    logic          in_run, in_lock;
    logic          host_prio;
    logic          gnt_i, gnt_d, gnt_h;

    logic [15:0]   win_addr;
    logic [15:0]   win_wdata;
    logic [1:0]    win_we;

    always_comb begin
        dreq      = bus.d_oe | bus.d_we0 | bus.d_we1;
        d_wr      = bus.d_we0 | bus.d_we1;
        in_run    = ~rst & (state_q == ST_RUN);
        in_lock   = ~rst & (state_q == ST_LOCK);
        host_prio = bus.h_req & (starve_q == STARVE_MAX);

        gnt_h = (in_run & bus.h_req & (host_prio | ~dreq)) | (in_lock & bus.h_req);
        gnt_d = in_run & dreq & ~host_prio;
        gnt_i = in_run & bus.i_req & ~dreq & ~bus.h_req;
    end

    // Winner drives the SRAM; a combined oe+we data request counts as a write.
    always_comb begin
        win_addr  = bus.i_addr;
        win_wdata = 16'h0000;
        win_we    = 2'b00;
        if (gnt_d) begin
            win_addr  = bus.d_addr;
            win_wdata = bus.d_wdata;
            win_we    = {bus.d_we1, bus.d_we0};
        end else if (gnt_h) begin
            win_addr  = bus.h_addr;
            win_wdata = bus.h_wdata;
            win_we    = bus.h_we ? 2'b11 : 2'b00;
        end
    end

    assign bus.m_en    = gnt_i | gnt_d | gnt_h;
    assign bus.m_we    = win_we;
    assign bus.m_addr  = win_addr[AW:1];
    assign bus.m_wdata = win_wdata;
    assign bus.h_gnt   = gnt_h;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.i_addr[0], bus.d_addr[0], bus.h_addr[0]};

    // A fetch that loses to a granted data access is refetched, so it is not a stall.
    assign bus.core_stall = ~rst & ((state_q != ST_RUN)
                                    | (dreq & ~gnt_d)
                                    | (bus.i_req & ~gnt_i & ~dreq));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = bus.h_lock ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = bus.h_lock ? ST_LOCK  : ST_RUN;
            ST_LOCK:  state_d = bus.h_lock ? ST_LOCK  : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.h_req || gnt_h) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
        if (state_d == ST_LOCK) begin
            starve_d = '0;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (gnt_d && !d_wr) begin
            tag_d = TAG_D;
        end else if (gnt_h && !bus.h_we) begin
            tag_d = TAG_H;
        end else if (gnt_i) begin
            tag_d = TAG_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            tag_q    <= TAG_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            starve_q <= starve_d;
        end
    end

    // Returns are masked during reset so a pending read is dropped immediately.
    assign bus.i_rvalid = ~rst & (tag_q == TAG_I);
    assign bus.d_rvalid = ~rst & (tag_q == TAG_D);
    assign bus.h_rvalid = ~rst & (tag_q == TAG_H);
    assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : 16'h0000;
    assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : 16'h0000;
    assign bus.h_rdata  = bus.h_rvalid ? bus.m_rdata : 16'h0000;
    assign bus.h_locked = ~rst & (state_q == ST_LOCK);
endmodule
